// File: rtl/adder_chain_pkg.sv
// adder_chain_pkg: default sizing and word-counter width for the adder chain feeder.
package adder_chain_pkg;
    localparam int DEF_MIN_WIDTH = 8;
    localparam int DEF_ADDER_NUM = 4;

    function automatic int wcnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage synchronous-reset shift register; DEPTH=0 is a wire.
module skew_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_d,
    output logic [WIDTH-1:0] out_d
);
    generate
        if (DEPTH == 0) begin : g_pass
            assign out_d = in_d;
        end else begin : g_sr
            logic [WIDTH-1:0] r_sr [DEPTH];
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sr <= '{default: '0};
                end else begin
                    r_sr[0] <= in_d;
                    for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
                end
            end
            assign out_d = r_sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/adder_chain_feeder.sv
// adder_chain_feeder: collects ADDER_NUM serial words per frame and launches them
// as a triangularly skewed operand vector with a chain-aligned result strobe.
module adder_chain_feeder
    import adder_chain_pkg::*;
#(
    parameter int MIN_WIDTH = DEF_MIN_WIDTH,
    parameter int ADDER_NUM = DEF_ADDER_NUM
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [MIN_WIDTH-1:0]           in_data,
    input  logic                           flush,
    output logic [MIN_WIDTH*ADDER_NUM-1:0] out_dout,
    output logic                           out_valid,
    output logic                           res_valid,
    output logic [15:0]                    frame_cnt
);
    localparam int WC = wcnt_width(ADDER_NUM);

    logic [WC-1:0]                  r_wcnt;
    logic [MIN_WIDTH-1:0]           r_hold [ADDER_NUM-1];
    logic [MIN_WIDTH*ADDER_NUM-1:0] r_launch;
    logic                           r_lv;
    logic [15:0]                    r_cnt;
    logic [MIN_WIDTH*ADDER_NUM-1:0] w_frame;
    logic                           w_acc;
    logic                           w_done;

    assign in_ready  = !rst;
    assign w_acc     = in_valid && in_ready && !flush;
    assign w_done    = w_acc && (r_wcnt == WC'(ADDER_NUM - 1));
    assign out_valid = r_lv;
    assign frame_cnt = r_cnt;

    // The last word bypasses the holding registers so the frame launches next cycle.
    for (genvar k = 0; k < ADDER_NUM; k++) begin : g_frame
        if (k == ADDER_NUM - 1) begin : g_last
            assign w_frame[k*MIN_WIDTH +: MIN_WIDTH] = in_data;
        end else begin : g_held
            assign w_frame[k*MIN_WIDTH +: MIN_WIDTH] = r_hold[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt   <= '0;
            r_hold   <= '{default: '0};
            r_launch <= '0;
            r_lv     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_launch <= w_done ? w_frame : '0;
            r_lv     <= w_done;
            r_cnt    <= r_cnt + 16'(r_lv);
            if (flush) begin
                r_wcnt <= '0;
                r_hold <= '{default: '0};
            end else if (w_acc) begin
                r_wcnt <= w_done ? '0 : r_wcnt + WC'(1);
                if (!w_done) r_hold[r_wcnt] <= in_data;
            end
        end
    end

    // Slot k is delayed k cycles so each chain layer sees its operand on time.
    for (genvar k = 0; k < ADDER_NUM; k++) begin : g_skew
        skew_delay_line #(.WIDTH(MIN_WIDTH), .DEPTH(k)) u_skew (
            .clk  (clk),
            .rst  (rst),
            .in_d (r_launch[k*MIN_WIDTH +: MIN_WIDTH]),
            .out_d(out_dout[k*MIN_WIDTH +: MIN_WIDTH])
        );
    end

    skew_delay_line #(.WIDTH(1), .DEPTH(ADDER_NUM)) u_res (
        .clk  (clk),
        .rst  (rst),
        .in_d (r_lv),
        .out_d(res_valid)
    );
endmodule

// File: tb/tb_adder_chain_feeder.sv
// tb_adder_chain_feeder: directed table, corner sequences and random traffic against a frame-level model.
module tb_adder_chain_feeder;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           flush = 1'b0;
    logic [W*N-1:0] out_dout;
    logic           out_valid;
    logic           res_valid;
    logic [15:0]    frame_cnt;

    adder_chain_feeder #(.MIN_WIDTH(W), .ADDER_NUM(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .out_dout (out_dout),
        .out_valid(out_valid),
        .res_valid(res_valid),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int           m_t[$];
    logic [W*N-1:0] m_f[$];
    logic [W-1:0] m_coll[$];

    typedef struct {
        logic           v;
        logic [W-1:0]   d;
        logic           ov;
        logic           rv;
        logic [W*N-1:0] dout;
        logic [15:0]    cnt;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Apply inputs for this cycle and compare outputs with the frame-level model.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic f, input logic r);
        logic [W*N-1:0] ed;
        logic ev, er;
        int ec;
        in_valid = v; in_data = d; flush = f; rst = r;
        ed = '0; ev = 0; er = 0; ec = 0;
        foreach (m_t[i]) begin
            if (m_t[i] == cyc) ev = 1;
            if (m_t[i] + N == cyc) er = 1;
            if (m_t[i] < cyc) ec++;
            for (int k = 0; k < N; k++)
                if (m_t[i] + k == cyc) ed[k*W +: W] = m_f[i][k*W +: W];
        end
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(!r));
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("res_valid", 64'(res_valid), 64'(er));
        chk("out_dout", 64'(out_dout), 64'(ed));
        chk("frame_cnt", 64'(frame_cnt), 64'(16'(ec)));
    endtask

    task automatic advance();
        logic [W*N-1:0] fr;
        if (rst) begin
            m_t.delete(); m_f.delete(); m_coll.delete();
        end else if (flush) begin
            m_coll.delete();
        end else if (in_valid) begin
            m_coll.push_back(in_data);
            if (m_coll.size() == N) begin
                for (int k = 0; k < N; k++) fr[k*W +: W] = m_coll[k];
                m_t.push_back(cyc + 1);
                m_f.push_back(fr);
                m_coll.delete();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic f, input logic r);
        drive(v, d, f, r);
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    vec_t tbl[10];
    logic [W-1:0] b2b[8];
    logic [15:0] c0;

    initial begin
        tbl[0] = '{1, 8'd1, 0, 0, 32'h0, 16'd0};
        tbl[1] = '{1, 8'd2, 0, 0, 32'h0, 16'd0};
        tbl[2] = '{1, 8'd3, 0, 0, 32'h0, 16'd0};
        tbl[3] = '{1, 8'd4, 0, 0, 32'h0, 16'd0};
        tbl[4] = '{0, 8'd0, 1, 0, 32'h00000001, 16'd0};
        tbl[5] = '{0, 8'd0, 0, 0, 32'h00000200, 16'd1};
        tbl[6] = '{0, 8'd0, 0, 0, 32'h00030000, 16'd1};
        tbl[7] = '{0, 8'd0, 0, 0, 32'h04000000, 16'd1};
        tbl[8] = '{0, 8'd0, 0, 1, 32'h0, 16'd1};
        tbl[9] = '{0, 8'd0, 0, 0, 32'h0, 16'd1};
        b2b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd20, 8'd30, 8'd40};

        rst = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].d, 0, 0);
            chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].ov));
            chk("tbl_res_valid", 64'(res_valid), 64'(tbl[i].rv));
            chk("tbl_out_dout", 64'(out_dout), 64'(tbl[i].dout));
            chk("tbl_frame_cnt", 64'(frame_cnt), 64'(tbl[i].cnt));
            advance();
        end

        for (int i = 0; i < 8; i++) step(1, b2b[i], 0, 0);
        idle(8);

        for (int i = 0; i < 8; i++) step(i % 2 == 0, 8'(5 + i / 2), 0, 0);
        idle(6);

        c0 = frame_cnt;
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 9, 0, 0);
        idle(6);
        chk("flush_mid_cnt", 64'(frame_cnt - c0), 64'd1);

        c0 = frame_cnt;
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        step(1, 3, 0, 0);
        step(1, 4, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 8'(5 + i), 0, 0);
        idle(8);
        chk("collision_cnt", 64'(frame_cnt - c0), 64'd1);

        for (int i = 0; i < 4; i++) step(1, 8'(i + 1), 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        idle(8);
        chk("reset_launch_cnt", 64'(frame_cnt), 64'd0);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 63) == 0);
        idle(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adder_chain_feeder.md
Name:
adder_chain_feeder

Overview:
- Upstream operand stage for the pipelined adder chain.
- Accepts a serial stream of MIN_WIDTH-bit words. Collects ADDER_NUM words into one frame.
- Launches the frame as a packed, triangularly skewed vector: slot k is presented k cycles after slot 0, so each chain layer sees its operand in the cycle it samples.
- Also produces a result-valid strobe aligned with the chain output.

Parameters:
- MIN_WIDTH, 8, width of one operand word.
- ADDER_NUM, 4, words per frame and chain depth. Legal range is 2 or more.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data carries a word this cycle.
- in_ready  output  1  feeder can accept a word.
- in_data  input  MIN_WIDTH  operand word. Word 0 of a frame arrives first.
- flush  input  1  synchronous discard of the partially collected frame.
- out_dout  output  MIN_WIDTH*ADDER_NUM  skewed operand vector. Slot k occupies bits [k*MIN_WIDTH +: MIN_WIDTH].
- out_valid  output  1  slot 0 of a launched frame is on out_dout this cycle.
- res_valid  output  1  chain result for a frame is valid this cycle.
- frame_cnt  output  16  launched-frame counter, wraps modulo 2^16.

Behaviour:
- Reset: while rst=1 at a rising edge, the following are cleared:
  - word counter and holding registers
  - every skew register (so all out_dout slots read 0)
  - valid pipeline (out_valid=0, res_valid=0)
  - frame_cnt=0
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after rst falls.
- Reset mid-frame or mid-launch: all partial and in-flight data is dropped. No res_valid is emitted for those frames.
- Handshake: a word is accepted when in_valid && in_ready. Outside reset, in_ready is constantly 1, because the skew pipe never stalls.
- Collection:
  - The word counter wcnt has width max(1, $clog2(ADDER_NUM)).
  - An accepted word goes to hold[wcnt], then wcnt increments.
  - The accept with wcnt==ADDER_NUM-1 completes the frame, and wcnt wraps to 0 in the same cycle.
  - The next frame's word 0 may be accepted in the very next cycle. Back-to-back frames every ADDER_NUM cycles are supported.
- Launch:
  - If frame completion occurs at cycle C, then T=C+1 is the launch cycle.
  - At T: slot 0 = word 0, out_valid=1, and frame_cnt increments (the value is visible at T+1).
  - Slot k (k>=1) carries word k at cycle T+k, via a k-deep shift register per slot.
  - Latency from the last word accepted to slot 0 out is 1 cycle.
  - The completed frame is copied to the launch stage at C. The holding registers are then free.
- Idle: in any cycle where no frame word is scheduled for slot k, slot k = 0. Idle cycles therefore contribute zero to chain sums.
- res_valid: out_valid delayed by exactly ADDER_NUM cycles through a shift register, so res_valid is high at T+ADDER_NUM.
- Overlap: successive frames occupy disjoint diagonals of the skew pipe. Slot values never mix between frames.
- Flush:
  - flush=1 clears wcnt and hold in that cycle.
  - A word presented with flush in the same cycle is dropped. Flush wins.
  - Frames already launched (at or after C) complete unaffected, including res_valid.
  - Flush coinciding with the completing accept drops that frame. No launch occurs.
- Arithmetic: none in this block. Data is passed bit-exact with no sign handling.

Decomposition:
- Shared package (adder_chain_pkg): localparams for the default MIN_WIDTH and ADDER_NUM, plus a function for word-counter width, max(1, $clog2(n)).
- Natural sub-module: skew_delay_line (parameters WIDTH and DEPTH).
  - A synchronous-reset shift register.
  - Instantiated once per slot k with DEPTH=k (DEPTH=0 is a passthrough).
  - Reused with WIDTH=1, DEPTH=ADDER_NUM for res_valid.

Test Plan:
- Reset then single frame (W=8, N=4): words 1,2,3,4 on cycles 0-3 -> out_valid at cycle 4 with slot0=1; slot1=2 at 5, slot2=3 at 6, slot3=4 at 7; res_valid at 8; frame_cnt=1 at 5; all other slot values 0.
- Back-to-back: frames {1,2,3,4} then {10,20,30,40} with continuous in_valid -> out_valid at 4 and 8; slot3=4 at 7 and =40 at 11; res_valid at 8 and 12; no cross-frame mixing.
- Gapped input: in_valid toggling 1,0,1,0,... for words 5,6,7,8 -> launch exactly 1 cycle after word 8 is accepted; gaps do not affect skew timing.
- Flush mid-frame: words 1,2 then flush, then 9,9,9,9 -> only one launch, slots carry 9 each; frame_cnt=1.
- Flush collision: flush asserted with the 4th word of a frame -> no out_valid, no res_valid; the following full frame launches normally.
- Reset mid-launch: rst asserted at T+1 of a frame -> all slots 0 from the next cycle, res_valid never asserts for that frame, in_ready=0 during reset and 1 afterwards, frame_cnt=0.
